i2s_receiver: RTL and testbench
===============================

# i2s_receiver

Slave-mode I2S receiver, the receive-direction counterpart of the synth's I2S transmitter. It synchronises externally driven bit clock, word select and serial data into the master clock domain and deserialises left and right words. It presents each stereo frame as a pair of signed samples with a one-cycle valid strobe. Typical uses are audio input into the synth and loopback verification of the transmitter.

## Interface
- DATA_WIDTH, 16: bits captured per channel word; output sample width.
- clk  input  1  master clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- i2s_bclk  input  1  external I2S bit clock, asynchronous to clk.
- i2s_ws  input  1  external word select; 0 = left, 1 = right.
- i2s_sd  input  1  external serial data, MSB first.
- left_sample  output  DATA_WIDTH  signed left word of the last complete frame.
- right_sample  output  DATA_WIDTH  signed right word of the last complete frame.
- sample_valid  output  1  one-clk pulse when left_sample and right_sample update together.
- locked  output  1  high once word alignment has been acquired.

## Operation
- **Synchronisers.** i2s_bclk, i2s_ws and i2s_sd each pass through a 2-flop synchroniser (s1, s2). A third register s3 holds the previous s2 of bclk.
- **Bit-clock edge.** bclk_rise = s2 & ~s3. ws and sd are sampled only on bclk_rise, using their s2 values. All three inputs therefore have equal latency.
- **Per-edge state.** On each bclk_rise the block keeps:
  - ws_prev: ws at the previous rise.
  - shift register: DATA_WIDTH bits.
  - bit_cnt: saturates at DATA_WIDTH.
- **Word boundary.** Per I2S, ws changes one bit before the MSB. A rise where ws ≠ ws_prev carries the LSB-slot bit of the word belonging to ws_prev.
- **State UNLOCKED** (after reset):
  - Bits are discarded.
  - On the first rise with ws ≠ ws_prev: clear the shift register, set bit_cnt = 0, go to RECEIVING. No word is emitted.
  - The very first rise after reset only loads ws_prev; it never counts as a transition.
- **State RECEIVING, each bclk_rise:**
  - If bit_cnt < DATA_WIDTH: shift sd into the LSB and increment bit_cnt. Otherwise the bit is ignored (slot longer than DATA_WIDTH).
  - If ws ≠ ws_prev, the word is complete:
    - Apply the shift rule above to the boundary bit first.
    - Left-justify: word = shift << (DATA_WIDTH − bit_cnt). Short slots are zero-padded in the LSBs.
    - Store the word in the holding register for channel ws_prev.
    - Clear the shift register and bit_cnt.
- **Frame commit.** When a right word completes (ws_prev = 1, ws = 0) and a left word has been held since the previous commit:
  - Copy both held words to left_sample and right_sample.
  - Pulse sample_valid.
  - If no left word is held (lock acquired mid-right), no commit and no pulse.
- **Output meaning.** Words are raw two's-complement; no sign extension is needed since width is preserved.
- **locked** = state is RECEIVING.
- **Reset values** (rst low, async): all outputs 0 and locked = 0. Synchronisers, counters and holding registers are cleared; state is UNLOCKED.
- **Reset mid-frame** discards partial words. Lock must be reacquired, so the first full frame after reset is never reported.

## Timing
- **Output latency.** Number clk edges from edge 1, the first edge where s1 captures bclk high. bclk_rise is valid between edges 2 and 3. The shift register, state and outputs update on edge 3. sample_valid is high for exactly the cycle after edge 3 of the committing bclk rise.
- **Input constraints:**
  - i2s_bclk high and low phases ≥ 3 clk periods each.
  - i2s_ws and i2s_sd stable ≥ 3 clk periods around the bclk rising edge.
- **Throughput.** At most one sample_valid per I2S frame.
- **Output stability.** left_sample and right_sample hold between commits.

## Test plan
- **16-bit slots, basic capture.** Idle after reset, then frames with left 0x1234 and right 0xABCD, bclk = clk/8.
  - No sample_valid for the partial first frame.
  - The second frame commit gives left_sample = 0x1234, right_sample = 0xABCD and a one-cycle pulse.
  - locked rises on the first ws edge.
- **32-bit slots.** Left 0x7FFF_5555, right 0x8000_AAAA.
  - Outputs are 0x7FFF and 0x8000.
  - Trailing bits are ignored, including the boundary bit.
- **8-bit slots.** Left 0xA5, right 0x3C.
  - Outputs are 0xA500 and 0x3C00.
- **Latency check.** Raise i2s_bclk for the committing LSB bit with ws already toggled.
  - sample_valid is high exactly after the 3rd clk edge counted from the first edge sampling bclk = 1.
- **Reset mid-word.** Assert rst low for 2 clk during the left word.
  - All outputs are 0 immediately (asynchronous).
  - The next partial frame gives no pulse.
  - The following full frame reports correctly.
- **Lock mid-right.** Lock is first acquired on a ws 0→1 transition.
  - The right word completes with no pulse.
  - The next complete left + right pair commits.

Source files
------------

// File: rtl/i2s_receiver.sv
// i2s_receiver: slave-mode I2S deserialiser that outputs signed stereo frames with a one-cycle valid pulse.
// The bit clock is synchronised into clk and edge-detected, so ws and sd see the same latency as bclk.
module i2s_receiver #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i2s_bclk,
  input  logic                         i2s_ws,
  input  logic                         i2s_sd,
  output logic signed [DATA_WIDTH-1:0] left_sample,
  output logic signed [DATA_WIDTH-1:0] right_sample,
  output logic                         sample_valid,
  output logic                         locked
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  typedef enum logic {UNLOCKED, RECEIVING} state_t;
  state_t r_state, w_next;
  logic r_bclk_s1, r_bclk_s2, r_bclk_s3, r_ws_s1, r_ws_s2, r_sd_s1, r_sd_s2;
  logic r_primed, r_ws_prev, r_left_have;
  logic [DATA_WIDTH-1:0] r_shift, r_left_hold, w_shift, w_word;
  logic [CW-1:0] r_cnt, w_cnt;
  logic w_rise, w_edge;
  assign w_rise = r_bclk_s2 & ~r_bclk_s3;
  assign w_edge = r_primed & (r_ws_s2 != r_ws_prev);
  assign locked = (r_state == RECEIVING);
  always_comb begin
    w_shift = r_shift;
    w_cnt   = r_cnt;
    if (r_cnt < CW'(DATA_WIDTH)) begin
      w_shift = {r_shift[DATA_WIDTH-2:0], r_sd_s2};
      w_cnt   = r_cnt + 1'b1;
    end
    // left-justify so short slots come out zero-padded in the LSBs
    w_word = w_shift << (CW'(DATA_WIDTH) - w_cnt);
    w_next = (w_rise && w_edge) ? RECEIVING : r_state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= UNLOCKED;
    else      r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {r_bclk_s1, r_bclk_s2, r_bclk_s3} <= '0;
      {r_ws_s1, r_ws_s2, r_sd_s1, r_sd_s2} <= '0;
      r_primed     <= 1'b0;
      r_ws_prev    <= 1'b0;
      r_left_have  <= 1'b0;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_left_hold  <= '0;
      left_sample  <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
    end else begin
      {r_bclk_s1, r_bclk_s2, r_bclk_s3} <= {i2s_bclk, r_bclk_s1, r_bclk_s2};
      {r_ws_s1, r_ws_s2} <= {i2s_ws, r_ws_s1};
      {r_sd_s1, r_sd_s2} <= {i2s_sd, r_sd_s1};
      sample_valid <= 1'b0;
      if (w_rise) begin
        r_primed  <= 1'b1;
        r_ws_prev <= r_ws_s2;
        if (w_edge) begin
          r_shift <= '0;
          r_cnt   <= '0;
          if (r_state == RECEIVING) begin
            if (!r_ws_prev) begin
              r_left_hold <= w_word;
              r_left_have <= 1'b1;
            end else if (r_left_have) begin
              left_sample  <= r_left_hold;
              right_sample <= w_word;
              sample_valid <= 1'b1;
              r_left_have  <= 1'b0;
            end
          end
        end else if (r_state == RECEIVING) begin
          r_shift <= w_shift;
          r_cnt   <= w_cnt;
        end
      end
    end
  end
endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: drives I2S frames of varying slot lengths and checks every cycle against a queue-based frame model.
module tb_i2s_receiver;
  localparam int DW = 16;
  logic clk = 1'b0, rst = 1'b0, bclk = 1'b0, ws = 1'b0, sd = 1'b0;
  logic [DW-1:0] left_sample, right_sample;
  logic sample_valid, locked;
  int total = 0, bad = 0, cyc = 0, rise_cyc = 0, pulses = 0, pend_cnt = 0, p0;
  bit m_primed, m_locked, m_prev, m_lheld;
  bit q[$];
  logic [DW-1:0] m_lword, exp_l = '0, exp_r = '0, p_l, p_r;
  logic exp_v = 1'b0, exp_lk = 1'b0, p_lk, p_commit;

  i2s_receiver #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .i2s_bclk(bclk), .i2s_ws(ws), .i2s_sd(sd),
    .left_sample(left_sample), .right_sample(right_sample),
    .sample_valid(sample_valid), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
    end
  endtask

  function automatic void model_reset();
    m_primed = 0; m_locked = 0; m_prev = 0; m_lheld = 0; q.delete();
    exp_l = '0; exp_r = '0; exp_v = 0; exp_lk = 0; pend_cnt = 0;
  endfunction

  // Word = first DW received bits of the slot, MSB first, zero-filled when the slot is shorter.
  function automatic void model_rise(input logic w, input logic d);
    logic [DW-1:0] word;
    p_commit = 0;
    if (!m_primed) m_primed = 1;
    else if (!m_locked) begin
      if (w != m_prev) begin m_locked = 1; q.delete(); end
    end else begin
      q.push_back(d);
      if (w != m_prev) begin
        word = '0;
        for (int i = 0; i < DW; i++) if (i < q.size()) word[DW-1-i] = q[i];
        if (!m_prev) begin m_lword = word; m_lheld = 1; end
        else if (m_lheld) begin p_commit = 1; p_l = m_lword; p_r = word; m_lheld = 0; end
        q.delete();
      end
    end
    m_prev = w;
    p_lk = m_locked;
    pend_cnt = 3;
  endfunction

  always @(posedge clk) begin
    cyc++;
    #1;
    exp_v = 0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        exp_lk = p_lk;
        if (p_commit) begin exp_l = p_l; exp_r = p_r; exp_v = 1; end
      end
    end
    check("left", 32'(left_sample), 32'(exp_l));
    check("right", 32'(right_sample), 32'(exp_r));
    check("valid", 32'(sample_valid), 32'(exp_v));
    check("locked", 32'(locked), 32'(exp_lk));
    if (sample_valid === 1'b1) begin
      pulses++;
      check("latency", cyc - rise_cyc, 3);
    end
  end

  task automatic send_bit(input logic w, input logic d);
    bclk = 0; ws = w; sd = d;
    repeat (4) @(negedge clk);
    bclk = 1;
    rise_cyc = cyc;
    model_rise(w, d);
    repeat (4) @(negedge clk);
  endtask

  task automatic send_slot(input logic ch, input int n, input logic [31:0] data);
    for (int i = n - 1; i >= 1; i--) send_bit(ch, data[i]);
    send_bit(~ch, data[0]);
  endtask

  task automatic send_frame(input int nl, input logic [31:0] l, input int nr, input logic [31:0] r);
    send_slot(1'b0, nl, l);
    send_slot(1'b1, nr, r);
  endtask

  task automatic do_reset();
    bclk = 0;
    repeat (4) @(negedge clk);
    rst = 0;
    model_reset();
    #1;
    check("async_left", 32'(left_sample), 0);
    check("async_right", 32'(right_sample), 0);
    check("async_locked", 32'(locked), 0);
    check("async_valid", 32'(sample_valid), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (5) @(negedge clk);
    send_frame(16, 32'h1234, 16, 32'hABCD);
    check("basic_no_pulse", pulses, 0);
    check("basic_locked", 32'(locked), 1);
    send_frame(16, 32'h1234, 16, 32'hABCD);
    check("basic_pulses", pulses, 1);
    check("basic_left", 32'(left_sample), 32'h1234);
    check("basic_right", 32'(right_sample), 32'hABCD);
    send_frame(32, 32'h7FFF_5555, 32, 32'h8000_AAAA);
    check("w32_pulses", pulses, 2);
    check("w32_left", 32'(left_sample), 32'h7FFF);
    check("w32_right", 32'(right_sample), 32'h8000);
    send_frame(8, 32'hA5, 8, 32'h3C);
    check("w8_pulses", pulses, 3);
    check("w8_left", 32'(left_sample), 32'hA500);
    check("w8_right", 32'(right_sample), 32'h3C00);
    for (int f = 0; f < 6; f++)
      send_frame($urandom_range(4, 32), $urandom, $urandom_range(4, 32), $urandom);
    check("rand_pulses", pulses, 9);
    d = 32'h0000_5A5A;
    for (int i = 15; i >= 10; i--) send_bit(1'b0, d[i]);
    do_reset();
    for (int i = 9; i >= 1; i--) send_bit(1'b0, d[i]);
    send_bit(1'b1, d[0]);
    p0 = pulses;
    send_slot(1'b1, 16, 32'h1111);
    check("rst_partial_no_pulse", pulses, p0);
    send_frame(16, 32'h0F0F, 16, 32'hF00F);
    check("rst_full_pulse", pulses, p0 + 1);
    check("rst_left", 32'(left_sample), 32'h0F0F);
    check("rst_right", 32'(right_sample), 32'hF00F);
    do_reset();
    send_slot(1'b0, 4, 32'h9);
    check("midright_locked", 32'(locked), 1);
    p0 = pulses;
    send_slot(1'b1, 16, 32'h2222);
    check("midright_no_pulse", pulses, p0);
    send_frame(16, 32'h8001, 16, 32'h7FFE);
    check("midright_pulse", pulses, p0 + 1);
    check("midright_left", 32'(left_sample), 32'h8001);
    check("midright_right", 32'(right_sample), 32'h7FFE);
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
